// File: rtl/gauss_window_gen.sv
// Raster-order 3x3 neighbourhood generator feeding gauss_blur.
// Line storage is a shift-register delay line; borders are zero-padded on the output register.
module gauss_window_gen #(
  parameter int IMAGE_WIDTH  = 128,
  parameter int IMAGE_HEIGHT = 128,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                            clk,
  input  logic                            Reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           in_pixel,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           window_pixel_1,
  output logic [DATA_WIDTH-1:0]           window_pixel_2,
  output logic [DATA_WIDTH-1:0]           window_pixel_3,
  output logic [DATA_WIDTH-1:0]           window_pixel_4,
  output logic [DATA_WIDTH-1:0]           window_pixel_5,
  output logic [DATA_WIDTH-1:0]           window_pixel_6,
  output logic [DATA_WIDTH-1:0]           window_pixel_7,
  output logic [DATA_WIDTH-1:0]           window_pixel_8,
  output logic [DATA_WIDTH-1:0]           window_pixel_9,
  output logic [$clog2(IMAGE_HEIGHT)-1:0] out_row,
  output logic [$clog2(IMAGE_WIDTH)-1:0]  out_col,
  output logic                            out_last
);

  localparam int W   = IMAGE_WIDTH;
  localparam int H   = IMAGE_HEIGHT;
  localparam int DW  = DATA_WIDTH;
  localparam int N   = W * H;
  localparam int RW  = $clog2(H);
  localparam int CLW = $clog2(W);
  localparam int KW  = $clog2(N + 1);
  localparam int FW  = $clog2(W + 2);
  localparam int DL  = 2 * W + 2;

  typedef enum logic [1:0] {S_FILL, S_STREAM, S_FLUSH, S_DRAIN} state_t;

  state_t            state, state_nxt;
  logic [KW-1:0]     in_cnt;
  logic [FW-1:0]     fl_cnt;
  logic [RW-1:0]     ld_row;
  logic [CLW-1:0]    ld_col;
  logic              accept;
  logic              load;
  logic              shift;
  logic [DW-1:0]     shift_in;
  logic [DW-1:0]     dl [DL];
  logic [9*DW-1:0]   taps;

  logic              vld_p0;
  logic [9*DW-1:0]   win_p0;
  logic [RW-1:0]     row_p0;
  logic [CLW-1:0]    col_p0;
  logic              last_p0;

  // Zero the taps that fall outside the frame; pixel p sits at slice p-1.
  function automatic logic [9*DW-1:0] pad_window(input logic [9*DW-1:0] w,
                                                 input logic top, input logic bot,
                                                 input logic lft, input logic rgt);
    logic [9*DW-1:0] o;
    o = w;
    for (int p = 0; p < 9; p++) begin
      if ((top && p < 3) || (bot && p > 5) || (lft && (p % 3) == 0) || (rgt && (p % 3) == 2))
        o[p*DW +: DW] = '0;
    end
    return o;
  endfunction

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state <= S_FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL:   if (accept && in_cnt == KW'(W))     state_nxt = S_STREAM;
      S_STREAM: if (accept && in_cnt == KW'(N - 1)) state_nxt = S_FLUSH;
      S_FLUSH:  if (load && fl_cnt == FW'(W))       state_nxt = S_DRAIN;
      S_DRAIN:  if (vld_p0 && out_ready && last_p0) state_nxt = S_FILL;
      default:                                      state_nxt = S_FILL;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    load     = 1'b0;
    case (state)
      S_FILL:   in_ready = 1'b1;
      S_STREAM: begin
        in_ready = !vld_p0 || out_ready;
        load     = in_valid && (!vld_p0 || out_ready);
      end
      S_FLUSH:  load = !vld_p0 || out_ready;
      default:  ;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign shift    = accept || (state == S_FLUSH && load);
  assign shift_in = (state == S_FLUSH) ? '0 : in_pixel;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      in_cnt <= '0;
      fl_cnt <= '0;
      ld_row <= '0;
      ld_col <= '0;
    end else begin
      if (accept)
        in_cnt <= (in_cnt == KW'(N - 1)) ? '0 : in_cnt + 1'b1;
      if (state == S_FLUSH && load)
        fl_cnt <= (fl_cnt == FW'(W)) ? '0 : fl_cnt + 1'b1;
      if (load) begin
        if (ld_col == CLW'(W - 1)) begin
          ld_col <= '0;
          ld_row <= (ld_row == RW'(H - 1)) ? '0 : ld_row + 1'b1;
        end else begin
          ld_col <= ld_col + 1'b1;
        end
      end
    end
  end

  // Delay line: dl[j] holds the pixel j+1 positions older than the newest one.
  always_ff @(posedge clk) begin
    if (shift) begin
      dl[0] <= shift_in;
      for (int i = 1; i < DL; i++) dl[i] <= dl[i-1];
    end
  end

  assign taps = {shift_in, dl[0], dl[1], dl[W-1], dl[W], dl[W+1], dl[2*W-1], dl[2*W], dl[2*W+1]};

  // Stage p0: registered, padded window held while the consumer stalls.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      vld_p0  <= 1'b0;
      win_p0  <= '0;
      row_p0  <= '0;
      col_p0  <= '0;
      last_p0 <= 1'b0;
    end else if (load) begin
      vld_p0  <= 1'b1;
      win_p0  <= pad_window(taps, ld_row == '0, ld_row == RW'(H - 1),
                            ld_col == '0, ld_col == CLW'(W - 1));
      row_p0  <= ld_row;
      col_p0  <= ld_col;
      last_p0 <= (ld_row == RW'(H - 1)) && (ld_col == CLW'(W - 1));
    end else if (out_ready) begin
      vld_p0  <= 1'b0;
    end
  end

  assign out_valid      = vld_p0;
  assign out_row        = row_p0;
  assign out_col        = col_p0;
  assign out_last       = last_p0;
  assign window_pixel_1 = win_p0[0*DW +: DW];
  assign window_pixel_2 = win_p0[1*DW +: DW];
  assign window_pixel_3 = win_p0[2*DW +: DW];
  assign window_pixel_4 = win_p0[3*DW +: DW];
  assign window_pixel_5 = win_p0[4*DW +: DW];
  assign window_pixel_6 = win_p0[5*DW +: DW];
  assign window_pixel_7 = win_p0[6*DW +: DW];
  assign window_pixel_8 = win_p0[7*DW +: DW];
  assign window_pixel_9 = win_p0[8*DW +: DW];

endmodule

// File: tb/tb_gauss_window_gen.sv
// Directed bench for gauss_window_gen on a 4x3 frame: streaming, backpressure, back-to-back, reset.
module tb_gauss_window_gen;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       Reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_pixel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] wp1, wp2, wp3, wp4, wp5, wp6, wp7, wp8, wp9;
  logic [1:0] out_row;
  logic [1:0] out_col;
  logic       out_last;

  int total = 0;
  int bad   = 0;

  int hand00  [9] = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
  int hand11  [9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
  int hand23  [9] = '{7, 8, 0, 11, 12, 0, 0, 0, 0};
  int hand2_00[9] = '{0, 0, 0, 0, 101, 102, 0, 105, 106};

  gauss_window_gen #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .DATA_WIDTH(8)) dut (
    .clk(clk), .Reset(Reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready),
    .window_pixel_1(wp1), .window_pixel_2(wp2), .window_pixel_3(wp3),
    .window_pixel_4(wp4), .window_pixel_5(wp5), .window_pixel_6(wp6),
    .window_pixel_7(wp7), .window_pixel_8(wp8), .window_pixel_9(wp9),
    .out_row(out_row), .out_col(out_col), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int dut_pix(input int p);
    case (p)
      1: return int'(wp1);
      2: return int'(wp2);
      3: return int'(wp3);
      4: return int'(wp4);
      5: return int'(wp5);
      6: return int'(wp6);
      7: return int'(wp7);
      8: return int'(wp8);
      default: return int'(wp9);
    endcase
  endfunction

  // Reference neighbourhood taken directly from the frame, zero outside it.
  function automatic int epix(input int base, input int r, input int c, input int p);
    int rr, cc;
    rr = r + (p - 1) / 3 - 1;
    cc = c + (p - 1) % 3 - 1;
    if (rr < 0 || rr >= H || cc < 0 || cc >= W) return 0;
    return base + rr * W + cc;
  endfunction

  task automatic run_frame(input int base, input int mode, input bit hold);
    int  sent  = 0;
    int  nout  = 0;
    int  acc_t = -1;
    int  vld_t = -1;
    bit  stalled = 0;
    int  snap [13];
    for (int t = 0; t < 400 && nout < N; t++) begin
      @(negedge clk);
      in_valid  = (sent < N) || hold;
      in_pixel  = (sent < N) ? 8'(base + sent) : 8'hEE;
      out_ready = (mode == 0) ? 1'b1 : ((t >= 10 && t < 15) ? 1'b0 : ((t % 2) == 0));
      #1;
      if (stalled) begin
        for (int p = 1; p <= 9; p++) chk("stall_pix", dut_pix(p), snap[p-1]);
        chk("stall_row",  int'(out_row),   snap[9]);
        chk("stall_col",  int'(out_col),   snap[10]);
        chk("stall_last", int'(out_last),  snap[11]);
        chk("stall_vld",  int'(out_valid), snap[12]);
      end
      stalled = out_valid && !out_ready;
      if (stalled) begin
        for (int p = 1; p <= 9; p++) snap[p-1] = dut_pix(p);
        snap[9] = int'(out_row); snap[10] = int'(out_col);
        snap[11] = int'(out_last); snap[12] = int'(out_valid);
        chk("bp_in_ready", int'(in_ready), 0);
      end
      if (sent >= N) chk("no_accept", int'(in_valid && in_ready), 0);
      if (out_valid && vld_t < 0) vld_t = t;
      if (out_valid && out_ready) begin
        for (int p = 1; p <= 9; p++) chk("win", dut_pix(p), epix(base, nout / W, nout % W, p));
        chk("row",  int'(out_row),  nout / W);
        chk("col",  int'(out_col),  nout % W);
        chk("last", int'(out_last), int'(nout == N - 1));
        for (int p = 1; p <= 9; p++) begin
          if (base == 1   && nout == 0)  chk("hand00",  dut_pix(p), hand00[p-1]);
          if (base == 1   && nout == 5)  chk("hand11",  dut_pix(p), hand11[p-1]);
          if (base == 1   && nout == 11) chk("hand23",  dut_pix(p), hand23[p-1]);
          if (base == 101 && nout == 0)  chk("hand2_00", dut_pix(p), hand2_00[p-1]);
        end
        nout++;
      end
      if (in_valid && in_ready && sent < N) begin
        if (sent == W + 1) acc_t = t;
        sent++;
      end
    end
    chk("nwin", nout, N);
    if (mode == 0) chk("latency", vld_t - acc_t, 1);
  endtask

  initial begin
    int sent;
    Reset     = 1'b1;
    in_valid  = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld",   int'(out_valid), 0);
    chk("rst_last",  int'(out_last),  0);
    chk("rst_row",   int'(out_row),   0);
    chk("rst_col",   int'(out_col),   0);
    chk("rst_ready", int'(in_ready),  1);
    for (int p = 1; p <= 9; p++) chk("rst_pix", dut_pix(p), 0);
    @(negedge clk);
    Reset = 1'b0;

    // Plain streaming frame, then confirm no extra windows appear.
    run_frame(1, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("extra_win", int'(out_valid), 0);
    end

    // Toggling ready with a long stall.
    run_frame(1, 1, 1'b0);

    // Back-to-back frames with in_valid held through flush/drain.
    run_frame(1, 0, 1'b1);
    run_frame(101, 0, 1'b0);

    // Asynchronous reset mid-stream after 8 accepted pixels.
    sent = 0;
    for (int t = 0; t < 50 && sent < 8; t++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_pixel  = 8'(sent + 50);
      out_ready = 1'b1;
      #1;
      if (in_valid && in_ready) sent++;
    end
    chk("pre_rst_cnt", sent, 8);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("pre_rst_vld", int'(out_valid), 1);
    #2;
    Reset = 1'b1;
    #1;
    chk("arst_vld",  int'(out_valid), 0);
    chk("arst_last", int'(out_last),  0);
    chk("arst_row",  int'(out_row),   0);
    chk("arst_col",  int'(out_col),   0);
    chk("arst_pix5", int'(wp5),       0);
    @(negedge clk);
    Reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", int'(in_ready), 1);
    run_frame(1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gauss_window_gen.md
Name: gauss_window_gen

Overview:
Upstream feeder for gauss_blur. Accepts a raster-order 8-bit pixel stream, one frame of IMAGE_HEIGHT x IMAGE_WIDTH pixels at a time. Emits one zero-padded 3x3 neighbourhood per pixel, in the same raster order, on nine ports that map one-to-one onto gauss_blur input_pixel_1..9. Uses valid/ready handshakes on both sides and internal line storage, so the blur stage no longer depends on a bench-side frame buffer.

Parameters:
IMAGE_WIDTH, 128, pixels per row (>=3)
IMAGE_HEIGHT, 128, rows per frame (>=2)
DATA_WIDTH, 8, bits per pixel

Ports:
clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
in_valid  in  1  in_pixel valid
in_ready  out  1  block accepts in_pixel this cycle
in_pixel  in  DATA_WIDTH  raster-order input pixel
out_valid  out  1  window valid
out_ready  in  1  consumer takes window this cycle
window_pixel_1..window_pixel_9  out  DATA_WIDTH each  3x3 window, row-major; 1=(r-1,c-1), 5=(r,c), 9=(r+1,c+1)
out_row  out  clog2(IMAGE_HEIGHT)  centre row r
out_col  out  clog2(IMAGE_WIDTH)  centre column c
out_last  out  1  window is the frame's final centre (H-1,W-1)

Behaviour:
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Linear index: k = r*W + c.
- Centre k's window is produced when input index k+W+1 is accepted, or during FLUSH when that index is beyond the frame.
- Storage: a 2W+3-deep delay line. Newest entry = index k+W+1. Taps at offsets 2W+2, 2W+1, 2W, W+2, W+1, W, 2, 1, 0 give pixels 1..9. Any structure with identical outputs is acceptable.
- Zero padding, applied on the registered output:
  - r=0: pixels 1-3 forced 0.
  - r=H-1: pixels 7-9 forced 0.
  - c=0: pixels 1, 4, 7 forced 0.
  - c=W-1: pixels 3, 6, 9 forced 0.
  - Corner windows apply both rules.
  - Stale delay-line contents from a previous frame must never reach the outputs.
- FSM:
  - FILL: in_ready=1. Accepts indices 0..W with no output. Acceptance of index W moves to STREAM.
  - STREAM: in_ready = !out_valid | out_ready. Each accepted input i loads the output register with the window for centre i-W-1; out_valid=1 the next cycle. Acceptance of index H*W-1 moves to FLUSH.
  - FLUSH: in_ready=0. Shifts zeros into the delay line. Each cycle with (!out_valid | out_ready), loads the next centre window. After W+1 windows are loaded, moves to DRAIN.
  - DRAIN: waits for the transfer with out_last=1, then returns to FILL.
- Latency: first out_valid rises 1 cycle after acceptance of input index W+1. Total windows per frame = H*W, with no gaps or duplicates.
- Output register: holds all outputs stable while out_valid & !out_ready.
- Counters: out_row and out_col advance c then r per loaded window and wrap to 0 after (H-1,W-1). out_last = (r==H-1 && c==W-1).
- Back-to-back frames: the next frame's pixels are accepted only after returning to FILL. There is no overlap in this revision.
- Simultaneous events: an output transfer and a new load in the same cycle is legal and gives full throughput. in_valid during FLUSH/DRAIN is ignored; the upstream must hold the pixel.
- Reset (any time, including mid-frame):
  - State -> FILL; all counters 0.
  - out_valid=0, out_last=0, window_pixel_* = 0, out_row = out_col = 0.
  - in_ready=1 on the first cycle after deassertion.
  - Delay-line contents need not be cleared; padding masks guarantee correctness.
- Width: pure data movement; no arithmetic on pixel values.

Test Plan:
- W=4, H=3, pixels 1..12 streamed, out_ready=1 -> first out_valid exactly 1 cycle after accepting pixel value 6.
  - Centre (0,0) = 0,0,0,0,1,2,0,5,6.
  - Centre (1,1) = 1,2,3,5,6,7,9,10,11.
  - Centre (2,3) = 7,8,0,11,12,0,0,0,0 with out_last=1.
  - Exactly 12 windows total.
- Same frame, out_ready toggled 1/0 each cycle plus a 5-cycle stall -> outputs stable while stalled; identical 12-window sequence; in_ready low whenever out_valid & !out_ready in STREAM.
- W=H=128, lena128 stream into gauss_window_gen + gauss_blur -> blurred output matches outPixel_gold_128 bit-exactly (PSNR 100); 16384 windows produced.
- Two frames back-to-back (1..12 then 101..112) -> the second frame's centre (0,0) = 0,0,0,0,101,102,0,105,106; no first-frame values leak into any second-frame window.
- Reset asserted asynchronously mid-STREAM after 8 accepted pixels -> out_valid=0 immediately; in_ready=1 after deassertion; a fresh 1..12 frame then reproduces scenario 1 exactly.
- in_valid held high through FLUSH -> no input accepted until DRAIN completes and the FSM is back in FILL.
